// File: rtl/binning_frame_ctrl.sv
// binning_frame_ctrl
//   Frame-level scheduler for the 4x4 binned mask stream. A capture is armed by
//   a request pulse or by continuous mode. The controller waits for the start
//   of a binned frame and writes each binned pixel into the write bank of a
//   ping-pong BRAM. A completed bank is handed to the reader only after the
//   reader has released the bank it currently holds.
//
// Ports
//   clk_in, rst_in        clock, synchronous active-high reset
//   capture_req_in        pulse: capture the next full frame
//   continuous_in         level: re-arm after every bank swap
//   bin_pixel_in/_hcount_in/_vcount_in/_valid_in   binned pixel stream
//   rd_busy_in            reader is still using rd_bank_out
//   wr_addr_out/_data_out/_en_out                 BRAM write port, {bank, index}
//   rd_bank_out           bank owned by the reader
//   frame_ready_out       pulse: rd_bank_out now holds a fresh frame
//   capturing_out         high while waiting for SOF or capturing
//   sync_err_out          pulse: pixel coordinates did not match the expected ones
//   drop_count_out        saturating count of SOFs missed while stalled in SWAP
module binning_frame_ctrl #(
  parameter int HRES        = 1280,
  parameter int VRES        = 720,
  parameter int KERNEL_SIZE = 4,
  localparam int HWIDTH = $clog2(HRES),
  localparam int VWIDTH = $clog2(VRES),
  localparam int BH     = HRES / KERNEL_SIZE,
  localparam int BV     = VRES / KERNEL_SIZE,
  localparam int BPIX   = BH * BV,
  localparam int PIX_W  = $clog2(BPIX)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              capture_req_in,
  input  logic              continuous_in,
  input  logic              bin_pixel_in,
  input  logic [HWIDTH-3:0] bin_hcount_in,
  input  logic [VWIDTH-3:0] bin_vcount_in,
  input  logic              bin_valid_in,
  input  logic              rd_busy_in,
  output logic [PIX_W:0]    wr_addr_out,
  output logic              wr_data_out,
  output logic              wr_en_out,
  output logic              rd_bank_out,
  output logic              frame_ready_out,
  output logic              capturing_out,
  output logic              sync_err_out,
  output logic [7:0]        drop_count_out
);

  localparam int HC_W = HWIDTH - 2;
  localparam int VC_W = VWIDTH - 2;
  localparam logic [HC_W-1:0] H_LAST = HC_W'(BH - 1);
  localparam logic [VC_W-1:0] V_LAST = VC_W'(BV - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_CAPTURE, S_SWAP} state_t;

  state_t            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              pending_q, pending_d;
  logic [HC_W-1:0]   exp_h_q, exp_h_d;
  logic [VC_W-1:0]   exp_v_q, exp_v_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [PIX_W:0]    wr_addr_q, wr_addr_d;
  logic              wr_data_q, wr_data_d;
  logic              frame_ready_q, frame_ready_d;
  logic              sync_err_q, sync_err_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic sof, coord_match, last_pix;

  assign sof         = bin_valid_in && (bin_hcount_in == '0) && (bin_vcount_in == '0);
  assign coord_match = (bin_hcount_in == exp_h_q) && (bin_vcount_in == exp_v_q);
  assign last_pix    = (exp_h_q == H_LAST) && (exp_v_q == V_LAST);

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    pending_d     = pending_q;
    exp_h_d       = exp_h_q;
    exp_v_d       = exp_v_q;
    pix_cnt_d     = pix_cnt_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = '0;
    wr_data_d     = 1'b0;
    frame_ready_d = 1'b0;
    sync_err_d    = 1'b0;
    drop_cnt_d    = drop_cnt_q;

    // A request that arrives while busy is remembered (one deep) and honoured
    // at the next swap.
    if (capture_req_in && (state_q != S_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (capture_req_in || continuous_in) begin
          state_d = S_WAIT_SOF;
        end
      end

      S_WAIT_SOF: begin
        if (sof) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {wr_bank_q, PIX_W'(0)};
          wr_data_d = bin_pixel_in;
          pix_cnt_d = PIX_W'(1);
          exp_h_d   = HC_W'(1);
          exp_v_d   = '0;
          state_d   = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (bin_valid_in) begin
          if (coord_match) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wr_bank_q, pix_cnt_q};
            wr_data_d = bin_pixel_in;
            if (last_pix) begin
              pix_cnt_d = '0;
              exp_h_d   = '0;
              exp_v_d   = '0;
              state_d   = S_SWAP;
            end else begin
              pix_cnt_d = pix_cnt_q + PIX_W'(1);
              if (exp_h_q == H_LAST) begin
                exp_h_d = '0;
                exp_v_d = exp_v_q + VC_W'(1);
              end else begin
                exp_h_d = exp_h_q + HC_W'(1);
              end
            end
          end else begin
            sync_err_d = 1'b1;
            if (sof) begin
              // Lost sync but this is a fresh frame start: restart in place.
              wr_en_d   = 1'b1;
              wr_addr_d = {wr_bank_q, PIX_W'(0)};
              wr_data_d = bin_pixel_in;
              pix_cnt_d = PIX_W'(1);
              exp_h_d   = HC_W'(1);
              exp_v_d   = '0;
            end else begin
              pix_cnt_d = '0;
              exp_h_d   = '0;
              exp_v_d   = '0;
              state_d   = S_WAIT_SOF;
            end
          end
        end
      end

      S_SWAP: begin
        if (!rd_busy_in) begin
          rd_bank_d     = wr_bank_q;
          wr_bank_d     = ~wr_bank_q;
          frame_ready_d = 1'b1;
          pending_d     = 1'b0;
          // A request in this very cycle is folded into the re-arm decision.
          if (continuous_in || pending_q || capture_req_in) begin
            state_d = S_WAIT_SOF;
          end else begin
            state_d = S_IDLE;
          end
        end else if (sof && (drop_cnt_q != 8'hFF)) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      pending_q     <= 1'b0;
      exp_h_q       <= '0;
      exp_v_q       <= '0;
      pix_cnt_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      sync_err_q    <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      pending_q     <= pending_d;
      exp_h_q       <= exp_h_d;
      exp_v_q       <= exp_v_d;
      pix_cnt_q     <= pix_cnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_ready_q <= frame_ready_d;
      sync_err_q    <= sync_err_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign wr_addr_out     = wr_addr_q;
  assign wr_data_out     = wr_data_q;
  assign wr_en_out       = wr_en_q;
  assign rd_bank_out     = rd_bank_q;
  assign frame_ready_out = frame_ready_q;
  assign capturing_out   = (state_q == S_WAIT_SOF) || (state_q == S_CAPTURE);
  assign sync_err_out    = sync_err_q;
  assign drop_count_out  = drop_cnt_q;

endmodule

// File: tb/tb_binning_frame_ctrl.sv
// tb_binning_frame_ctrl
//   Bench for binning_frame_ctrl at HRES=16, VRES=8 (4x2 binned frame, 8 pixels).
//   Expected BRAM writes are queued as pixels are driven and matched against the
//   write port as it fires; frame-level behaviour is checked by direct sequences
//   and a table of per-cycle vectors for the resynchronisation cases.
module tb_binning_frame_ctrl;
  localparam int HRES = 16;
  localparam int VRES = 8;
  localparam int BH   = 4;
  localparam int BPIX = 8;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       capture_req_in = 1'b0;
  logic       continuous_in = 1'b0;
  logic       bin_pixel_in = 1'b0;
  logic [1:0] bin_hcount_in = '0;
  logic [0:0] bin_vcount_in = '0;
  logic       bin_valid_in = 1'b0;
  logic       rd_busy_in = 1'b0;
  logic [3:0] wr_addr_out;
  logic       wr_data_out;
  logic       wr_en_out;
  logic       rd_bank_out;
  logic       frame_ready_out;
  logic       capturing_out;
  logic       sync_err_out;
  logic [7:0] drop_count_out;

  binning_frame_ctrl #(.HRES(HRES), .VRES(VRES), .KERNEL_SIZE(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .capture_req_in(capture_req_in),
    .continuous_in(continuous_in), .bin_pixel_in(bin_pixel_in),
    .bin_hcount_in(bin_hcount_in), .bin_vcount_in(bin_vcount_in),
    .bin_valid_in(bin_valid_in), .rd_busy_in(rd_busy_in),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .wr_en_out(wr_en_out),
    .rd_bank_out(rd_bank_out), .frame_ready_out(frame_ready_out),
    .capturing_out(capturing_out), .sync_err_out(sync_err_out),
    .drop_count_out(drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0] addr;
    logic       data;
  } wr_t;

  typedef struct {
    int h;
    int v;
    bit valid;
    bit expw;
    int idx;
    bit experr;
    bit expcap;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t tbl[15];
  int   n_vec = 0;
  int   n_miss = 0;
  int   fr_cnt = 0;
  int   err_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Write-port scoreboard and pulse counters, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (frame_ready_out) fr_cnt++;
    if (sync_err_out) err_cnt++;
    if (wr_en_out) begin
      check("write_into_reader_bank", int'(wr_addr_out[3] != rd_bank_out), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", int'(wr_addr_out), -1);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", int'(wr_addr_out), int'(mon_e.addr));
        check("write_data", int'(wr_data_out), int'(mon_e.data));
        $display("write addr %0d data %0d (expected addr %0d data %0d)",
                 wr_addr_out, wr_data_out, mon_e.addr, mon_e.data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_exp(input int addr, input bit d);
    wr_t w;
    w.addr = 4'(addr);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic pix(input int h, input int v, input bit expw, input int addr);
    bit p;
    p = 1'($urandom_range(0, 1));
    bin_hcount_in = 2'(h);
    bin_vcount_in = 1'(v);
    bin_pixel_in  = p;
    bin_valid_in  = 1'b1;
    if (expw) push_exp(addr, p);
    cyc();
    bin_valid_in = 1'b0;
  endtask

  task automatic frame(input bit expw, input int bank);
    for (int i = 0; i < BPIX; i++) pix(i % BH, i / BH, expw, bank * BPIX + i);
  endtask

  task automatic req_pulse();
    capture_req_in = 1'b1;
    cyc();
    capture_req_in = 1'b0;
  endtask

  task automatic idle_swap(input string name, input int exp_rd);
    cyc();
    check({name, "_frame_ready"}, int'(frame_ready_out), 1);
    check({name, "_rd_bank"}, int'(rd_bank_out), exp_rd);
    check({name, "_queue_drained"}, exp_q.size(), 0);
    $display("%s: frame_ready %0d rd_bank %0d (expected rd_bank %0d)",
             name, frame_ready_out, rd_bank_out, exp_rd);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wr_en"}, int'(wr_en_out), 0);
    check({name, "_wr_addr"}, int'(wr_addr_out), 0);
    check({name, "_wr_data"}, int'(wr_data_out), 0);
    check({name, "_rd_bank"}, int'(rd_bank_out), 1);
    check({name, "_frame_ready"}, int'(frame_ready_out), 0);
    check({name, "_capturing"}, int'(capturing_out), 0);
    check({name, "_sync_err"}, int'(sync_err_out), 0);
    check({name, "_drop_count"}, int'(drop_count_out), 0);
    $display("%s: reset outputs sampled", name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  fr_before;
    bit  got;

    // Resync vectors: {h, v, valid, write expected, index, sync_err, capturing}
    tbl[0] = '{0, 0, 1, 1, 0, 0, 1};
    tbl[1] = '{1, 0, 1, 1, 1, 0, 1};
    tbl[2] = '{2, 0, 0, 0, 0, 0, 1};  // not valid: ignored
    tbl[3] = '{0, 0, 1, 1, 0, 1, 1};  // SOF out of order: error, restart at 0
    tbl[4] = '{1, 0, 1, 1, 1, 0, 1};
    tbl[5] = '{3, 0, 1, 0, 0, 1, 1};  // skipped column: error, back to WAIT_SOF
    tbl[6] = '{2, 0, 1, 0, 0, 0, 1};  // ignored while waiting for SOF
    tbl[7] = '{0, 0, 1, 1, 0, 0, 1};
    for (int i = 1; i < BPIX; i++) tbl[7 + i] = '{i % BH, i / BH, 1, 1, i, 0, (i != BPIX - 1)};

    // Reset state
    repeat (3) cyc();
    check_reset_outputs("reset");
    rst_in = 1'b0;
    cyc();

    // Not armed: a full frame must produce no writes
    frame(1'b0, 0);
    cyc();
    check("idle_capturing", int'(capturing_out), 0);

    // Clean frame into bank 0, then next frame into bank 1
    req_pulse();
    check("armed_capturing", int'(capturing_out), 1);
    frame(1'b1, 0);
    check("last_pixel_capturing", int'(capturing_out), 0);
    idle_swap("frame1", 0);
    cyc();
    check("frame1_back_to_idle", int'(capturing_out), 0);
    req_pulse();
    frame(1'b1, 1);
    idle_swap("frame2", 1);

    // Arm mid-frame: nothing written until the next SOF
    req_pulse();
    pix(2, 0, 0, 0); pix(3, 0, 0, 0);
    for (int i = 0; i < BH; i++) pix(i, 1, 0, 0);
    frame(1'b1, 0);
    idle_swap("midstream", 0);

    // Resynchronisation table, write bank 1
    req_pulse();
    for (int k = 0; k < 15; k++) begin
      bit p;
      p = 1'($urandom_range(0, 1));
      bin_hcount_in = 2'(tbl[k].h);
      bin_vcount_in = 1'(tbl[k].v);
      bin_pixel_in  = p;
      bin_valid_in  = tbl[k].valid;
      if (tbl[k].expw) push_exp(BPIX + tbl[k].idx, p);
      cyc();
      check($sformatf("vec%0d_sync_err", k), int'(sync_err_out), int'(tbl[k].experr));
      check($sformatf("vec%0d_capturing", k), int'(capturing_out), int'(tbl[k].expcap));
      $display("vec%0d: h %0d v %0d valid %0d sync_err %0d (expected %0d)",
               k, tbl[k].h, tbl[k].v, tbl[k].valid, sync_err_out, tbl[k].experr);
    end
    bin_valid_in = 1'b0;
    idle_swap("resync", 1);

    // Reader busy at frame end: two SOFs dropped, request held as pending
    rd_busy_in = 1'b1;
    req_pulse();
    frame(1'b1, 0);
    fr_before = fr_cnt;
    cyc();
    check("busy_no_frame_ready", int'(frame_ready_out), 0);
    capture_req_in = 1'b1;
    pix(0, 0, 0, 0);
    capture_req_in = 1'b0;
    pix(1, 0, 0, 0); pix(2, 0, 0, 0);
    frame(1'b0, 0);
    cyc();
    check("busy_drop_count", int'(drop_count_out), 2);
    check("busy_rd_bank_held", int'(rd_bank_out), 1);
    check("busy_no_pulse_count", fr_cnt - fr_before, 0);
    rd_busy_in = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      cyc();
      if (frame_ready_out) got = 1'b1;
    end
    check("release_frame_ready_within_2", int'(got), 1);
    check("release_rd_bank", int'(rd_bank_out), 0);
    check("release_pending_rearm", int'(capturing_out), 1);
    check("release_drop_count_kept", int'(drop_count_out), 2);
    $display("busy: drop_count %0d rd_bank %0d after release", drop_count_out, rd_bank_out);

    // Continuous mode: three frames, banks alternate
    continuous_in = 1'b1;
    frame(1'b1, 1);
    idle_swap("cont1", 1);
    frame(1'b1, 0);
    idle_swap("cont2", 0);
    frame(1'b1, 1);
    idle_swap("cont3", 1);
    continuous_in = 1'b0;
    check("cont_rearmed", int'(capturing_out), 1);

    // Reset after 5 pixels: partial frame abandoned
    for (int i = 0; i < 5; i++) pix(i % BH, i / BH, 1, i);
    fr_before = fr_cnt;
    rst_in = 1'b1;
    cyc();
    check_reset_outputs("midreset");
    cyc();
    rst_in = 1'b0;
    for (int i = 5; i < BPIX; i++) pix(i % BH, i / BH, 0, 0);
    repeat (4) cyc();
    check("midreset_no_frame_ready", fr_cnt - fr_before, 0);
    check("midreset_idle", int'(capturing_out), 0);

    // Totals
    check("total_frame_ready_pulses", fr_cnt, 8);
    check("total_sync_err_pulses", err_cnt, 2);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
